// File: rtl/alu_mul_sequencer.sv
// Sequential 32x32 shift-add multiplier that borrows the datapath ALU for every add.
// Define MUL_SIGNED_EN to add the signed_mode port and the two's-complement NEG/FIX steps.
module alu_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
`ifdef MUL_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ci,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c
);

  localparam logic [3:0] OP_ADD = 4'b0000;
`ifdef MUL_SIGNED_EN
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBB = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_MUL, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DONE
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [5:0]       cnt;
`ifdef MUL_SIGNED_EN
  logic             sm;   // operation runs in signed mode: fixed NEG/FIX sequence
  logic             sgn;  // product must be negated at the end
  logic             brw;
`endif

  // ALU controls depend only on registered state, so alu_out settles within the cycle.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_ci = 1'b0;
    alu_op = OP_ADD;
    case (state)
      S_MUL: begin
        alu_a = hi;
        alu_b = lo[0] ? mc : '0;
      end
`ifdef MUL_SIGNED_EN
      S_NEG_A: begin
        alu_op = OP_SUB;
        alu_b  = mc;
      end
      S_NEG_B: begin
        alu_op = OP_SUB;
        alu_b  = lo;
      end
      S_FIX_LO: begin
        alu_op = OP_SUB;
        alu_b  = lo;
      end
      S_FIX_HI: begin
        alu_op = OP_SBB;
        alu_b  = hi;
        alu_ci = brw;
      end
`endif
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mc      <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod_hi <= '0;
      prod_lo <= '0;
`ifdef MUL_SIGNED_EN
      sm      <= 1'b0;
      sgn     <= 1'b0;
      brw     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mc   <= mcand;
            lo   <= mplier;
            hi   <= '0;
            cnt  <= '0;
            busy <= 1'b1;
`ifdef MUL_SIGNED_EN
            sm    <= signed_mode;
            sgn   <= signed_mode & (mcand[WIDTH-1] ^ mplier[WIDTH-1]);
            state <= signed_mode ? S_NEG_A : S_MUL;
`else
            state <= S_MUL;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        // 0 - x yields the magnitude; 0x80000000 maps to itself, which is right unsigned.
        S_NEG_A: begin
          if (mc[WIDTH-1]) mc <= alu_out;
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          if (lo[WIDTH-1]) lo <= alu_out;
          state <= S_MUL;
        end
`endif
        S_MUL: begin
          hi  <= {alu_c, alu_out[WIDTH-1:1]};
          lo  <= {alu_out[0], lo[WIDTH-1:1]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
`ifdef MUL_SIGNED_EN
            state <= sm ? S_FIX_LO : S_DONE;
`else
            state <= S_DONE;
`endif
          end
        end
`ifdef MUL_SIGNED_EN
        S_FIX_LO: begin
          if (sgn) lo <= alu_out;
          brw   <= alu_c;
          state <= S_FIX_HI;
        end
        S_FIX_HI: begin
          if (sgn) hi <= alu_out;
          state <= S_DONE;
        end
`endif
        S_DONE: begin
          prod_hi <= hi;
          prod_lo <= lo;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle 32×32 multiplier that drives the datapath ALU as its only arithmetic resource. It issues one ALU add per cycle using the shift-add algorithm and collects the ALU result and carry flag. It sits beside the ALU and owns the ALU's operand and opcode inputs while busy. It produces a 64-bit product with a start/busy/done handshake toward the control unit.

## Interface
- WIDTH, 32, operand width; must equal the ALU width; only 32 is supported.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- mcand  in  32  multiplicand, captured on the accepting edge
- mplier  in  32  multiplier, captured on the accepting edge
- signed_mode  in  1  two's-complement operands; port exists only with MUL_SIGNED_EN
- busy  out  1  high from the accepting edge until the edge that raises done
- done  out  1  one-cycle pulse; product valid
- prod_hi  out  32  product bits 63:32, held until the next accepted start
- prod_lo  out  32  product bits 31:0, held until the next accepted start
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_ci  out  1  ALU carry-in
- alu_op  out  4  ALU opcode: 0000 add, 0010 sub, 0011 sub-with-borrow
- alu_out  in  32  ALU result (combinational, same cycle)
- alu_c  in  1  ALU carry/borrow flag: bit 32 of the 33-bit result

## Operation
- States: IDLE, NEG_A, NEG_B, MUL, FIX_LO, FIX_HI, DONE. NEG_* and FIX_* exist only with MUL_SIGNED_EN.
- Registers: mc (32), hi (32), lo (32), cnt (6), sgn (1), brw (1).
- IDLE drives alu_a=0, alu_b=0, alu_ci=0, alu_op=0000.
- IDLE with start=1 performs the accept:
  - mc←mcand, lo←mplier, hi←0, cnt←0.
  - Next state is MUL, or NEG_A if signed.
- MUL cycle:
  - Drives alu_op=0000, alu_a=hi, alu_b = lo[0] ? mc : 0, alu_ci=0.
  - Update: hi←{alu_c, alu_out[31:1]}, lo←{alu_out[0], lo[31:1]}, cnt←cnt+1.
  - After the cnt=31 cycle, next state is FIX_LO if signed, else DONE.
- DONE: prod_hi←hi and prod_lo←lo on entry; done=1 for exactly one cycle; busy=0; return to IDLE.
- start while busy or in DONE is ignored; captured operands are unaffected.
- All arithmetic goes through the ALU. The block contains no adder except the cnt incrementer.

## Timing
- Reset (async, any state): state=IDLE. All registers and outputs are 0, including busy, done, prod_hi, prod_lo, alu_a, alu_b, alu_ci and alu_op=0000.
- Reset mid-operation aborts with no done pulse.
- Start is sampled on edge E0. The states occupy one cycle each after E0.
- Unsigned timing:
  - MUL occupies cycles E0+1..E0+32.
  - done is high in the cycle after E0+33.
  - Total latency is 33 edges.
- Signed timing:
  - Sequence is NEG_A, NEG_B, 32×MUL, FIX_LO, FIX_HI, DONE.
  - done follows E0+37; latency is fixed regardless of operand signs.
- ALU path is combinational within one cycle: outputs are registered-state driven and alu_out/alu_c are consumed at the same edge.
- A new start is accepted in the cycle done is high only after return to IDLE, so back-to-back spacing is latency+1 cycles.

## Configuration
- MUL_SIGNED_EN defined:
  - The signed_mode port exists. When signed_mode=1 on accept, sgn←mcand[31]^mplier[31].
  - NEG_A: op 0010, a=0, b=mc; mc←alu_out only if mc[31]. This gives magnitude; 0x80000000 stays 0x80000000, which is correct unsigned.
  - NEG_B: the same operation on lo.
  - FIX_LO: op 0010, a=0, b=lo; if sgn then lo←alu_out; brw←alu_c.
  - FIX_HI: op 0011, a=0, b=hi, ci=brw; if sgn then hi←alu_out.
  - When signed_mode=0, the block behaves as unsigned with 33-edge latency and skips the NEG/FIX states.
- Undefined: no signed_mode port; unsigned only; the NEG/FIX states are absent.

## Test plan
- 3 × 5 unsigned → prod_hi=0x00000000, prod_lo=0x0000000F; done exactly 33 edges after the start edge; busy high throughout.
- 0xFFFFFFFF × 0xFFFFFFFF → prod_hi=0xFFFFFFFE, prod_lo=0x00000001. This exercises alu_c capture every MUL cycle.
- Start 0x10 × 0x10, then pulse start with 7 × 7 at cycle 5 → the second start is ignored; result 0x00000100; a single done pulse.
- Deassert rst_n at cycle 10 of a multiply → busy=0, prod=0 immediately (async), no done; a fresh 2 × 9 afterwards yields 0x12.
- MUL_SIGNED_EN, signed_mode=1:
  - −3 × 7 → prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFEB, latency 37.
  - 0x80000000 × 0x80000000 → prod_hi=0x40000000, prod_lo=0x00000000.
- MUL_SIGNED_EN, signed_mode=0: 0xFFFFFFFF × 2 → prod_hi=0x00000001, prod_lo=0xFFFFFFFE, latency 33.
